// File: rtl/circulant_unrotate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : circulant_unrotate                                              |
// | Purpose  : Two-stage, flow-controlled left rotator that undoes the         |
// |            circulant shift on MSB-aligned QC-LDPC sub-blocks.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module circulant_unrotate #(
    parameter int MAX_BLOCK_SIZE = 64,
    parameter int TAG_W          = 8,
    localparam int WIDTH         = $clog2(MAX_BLOCK_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAX_BLOCK_SIZE-1:0] in_vector,
    input  logic [WIDTH-1:0]          shift_amount,
    input  logic [WIDTH-1:0]          width,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAX_BLOCK_SIZE-1:0] out_vector,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_err,
    output logic                      err_sticky
);

    localparam logic [WIDTH-1:0]          c_NULL_SHIFT = '1;
    localparam logic [MAX_BLOCK_SIZE-1:0] c_ALL_ONES   = '1;

    // Stage 1 registers
    logic                      r_s1_valid;
    logic [MAX_BLOCK_SIZE-1:0] r_s1_vec;
    logic [WIDTH-1:0]          r_s1_shift;
    logic [WIDTH-1:0]          r_s1_width;
    logic                      r_s1_null;
    logic                      r_s1_illegal;
    logic [TAG_W-1:0]          r_s1_tag;

    // Stage 2 (output) registers
    logic                      r_out_valid;
    logic [MAX_BLOCK_SIZE-1:0] r_out_vec;
    logic [TAG_W-1:0]          r_out_tag;
    logic                      r_out_err;
    logic                      r_err_sticky;

    logic                      w_adv;
    logic [MAX_BLOCK_SIZE-1:0] w_in_mask;
    logic                      w_in_null;
    logic                      w_in_illegal;
    logic [WIDTH:0]            w_rshift;
    logic [MAX_BLOCK_SIZE-1:0] w_s1_mask;
    logic [MAX_BLOCK_SIZE-1:0] w_rot;

    // Whole pipeline freezes only when the output holds a beat nobody takes.
    assign w_adv    = !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    assign w_in_mask    = ~(c_ALL_ONES >> width);
    assign w_in_null    = (shift_amount == c_NULL_SHIFT);
    assign w_in_illegal = !w_in_null && (shift_amount >= width);

    // Left rotation inside an MSB-aligned window of r_s1_width bits: bits
    // leaving the top of the window re-enter at its bottom edge, and anything
    // pushed below the window is masked off.
    assign w_rshift  = {1'b0, r_s1_width} - {1'b0, r_s1_shift};
    assign w_s1_mask = ~(c_ALL_ONES >> r_s1_width);
    assign w_rot     = (r_s1_null || r_s1_illegal) ? '0 :
                       (((r_s1_vec << r_s1_shift) | (r_s1_vec >> w_rshift)) & w_s1_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_vec     <= '0;
            r_s1_shift   <= '0;
            r_s1_width   <= '0;
            r_s1_null    <= 1'b0;
            r_s1_illegal <= 1'b0;
            r_s1_tag     <= '0;
            r_out_valid  <= 1'b0;
            r_out_vec    <= '0;
            r_out_tag    <= '0;
            r_out_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_adv) begin
                r_s1_valid  <= in_valid;
                r_out_valid <= r_s1_valid;
                if (in_valid) begin
                    r_s1_vec     <= in_vector & w_in_mask;
                    r_s1_shift   <= shift_amount;
                    r_s1_width   <= width;
                    r_s1_null    <= w_in_null;
                    r_s1_illegal <= w_in_illegal;
                    r_s1_tag     <= in_tag;
                end
                // Output data only moves with a real beat so it reads zero
                // after reset until the first beat arrives.
                if (r_s1_valid) begin
                    r_out_vec <= w_rot;
                    r_out_tag <= r_s1_tag;
                    r_out_err <= r_s1_illegal;
                end
            end
            if (r_out_valid && out_ready && r_out_err) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_vector = r_out_vec;
    assign out_tag    = r_out_tag;
    assign out_err    = r_out_err;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_circulant_unrotate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_circulant_unrotate                                           |
// | Purpose  : Scoreboard bench for circulant_unrotate at MAX_BLOCK_SIZE = 8.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_circulant_unrotate;

    localparam int MAX_BLOCK_SIZE = 8;
    localparam int TAG_W          = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_vector = '0;
    logic [2:0] shift_amount = '0;
    logic [2:0] width = '0;
    logic [7:0] in_tag = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_vector;
    logic [7:0] out_tag;
    logic       out_err;
    logic       err_sticky;

    circulant_unrotate #(
        .MAX_BLOCK_SIZE(MAX_BLOCK_SIZE),
        .TAG_W         (TAG_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vector   (in_vector),
        .shift_amount(shift_amount),
        .width       (width),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vector  (out_vector),
        .out_tag     (out_tag),
        .out_err     (out_err),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vec;
        logic [7:0] tag;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic m_v1 = 1'b0;
    logic m_v2 = 1'b0;
    logic m_sticky = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Element-wise reference: out element j = in element (j + s) mod w.
    function automatic logic [8:0] model(input logic [7:0] v, input logic [2:0] w, input logic [2:0] s);
        logic [7:0] r;
        r = '0;
        if (s == 3'd7) return 9'h000;
        if (s >= w) return 9'h100;
        for (int j = 0; j < int'(w); j++) begin
            r[7 - j] = v[7 - ((j + int'(s)) % int'(w))];
        end
        return {1'b0, r};
    endfunction

    // One clock: drive at negedge, check outputs, then step the valid model.
    task automatic cycle(input logic v, input logic [7:0] vec, input logic [2:0] s,
                         input logic [2:0] w, input logic [7:0] tg, input logic [7:0] ev,
                         input logic ee, input logic ordy, output logic acc);
        logic adv;
        exp_t e;
        @(negedge clk);
        in_valid     = v;
        in_vector    = vec;
        shift_amount = s;
        width        = w;
        in_tag       = tg;
        out_ready    = ordy;
        #1;
        adv = !(m_v2 && !ordy);
        check("out_valid", out_valid, m_v2);
        check("in_ready", in_ready, adv);
        check("err_sticky", err_sticky, m_sticky);
        if (m_v2) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got out_valid=1 expected no beat at %0t", $time);
            end else begin
                e = sb[0];
                check("out_vector", out_vector, e.vec);
                check("out_tag", out_tag, e.tag);
                check("out_err", out_err, e.err);
                if (ordy) begin
                    void'(sb.pop_front());
                    if (e.err) m_sticky = 1'b1;
                end
            end
        end
        acc = v && adv;
        if (acc) sb.push_back('{vec: ev, tag: tg, err: ee});
        if (adv) begin
            m_v2 = m_v1;
            m_v1 = acc;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 8'h00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_v1     = 1'b0;
        m_v2     = 1'b0;
        m_sticky = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_vector", out_vector, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        logic       acc;
        logic [7:0] orig, rot, msk, bv;
        logic [2:0] bw, bs;
        logic [8:0] bexp;
        int         sent, guard;

        do_reset();

        // Directed beats with spec-given answers
        cycle(1'b1, 8'hB0, 3'd2, 3'd5, 8'h11, 8'hD0, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'hFF, 3'd0, 3'd5, 8'h12, 8'hF8, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'hFF, 3'd7, 3'd5, 8'h13, 8'h00, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'hA5, 3'd7, 3'd0, 8'h14, 8'h00, 1'b0, 1'b1, acc);
        idle(3);

        // Round trip: right-rotate in the bench, expect the masked original back
        for (int w = 1; w < 8; w++) begin
            for (int s = 0; s < w; s++) begin
                orig = 8'($urandom);
                rot  = '0;
                msk  = '0;
                for (int j = 0; j < w; j++) begin
                    rot[7 - ((j + s) % w)] = orig[7 - j];
                    msk[7 - j] = 1'b1;
                end
                cycle(1'b1, rot, 3'(s), 3'(w), 8'(w * 8 + s), orig & msk, 1'b0, 1'b1, acc);
            end
        end
        idle(3);
        check("rt_drain", sb.size(), 0);

        // Backpressure: 10 tagged beats, out_ready random
        sent  = 0;
        guard = 0;
        bv    = 8'($urandom);
        bw    = 3'($urandom_range(1, 7));
        bs    = 3'($urandom_range(0, 6));
        while (sent < 10 && guard < 300) begin
            bexp = model(bv, bw, bs);
            cycle(1'b1, bv, bs, bw, 8'(8'h40 + sent), bexp[7:0], bexp[8],
                  1'($urandom_range(0, 1)), acc);
            if (acc) begin
                sent++;
                bv = 8'($urandom);
                bw = 3'($urandom_range(1, 7));
                bs = 3'($urandom_range(0, 6));
            end
            guard++;
        end
        check("bp_sent", sent, 10);
        for (int k = 0; k < 40 && (m_v1 || m_v2); k++) begin
            cycle(1'b0, 8'h00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 1'($urandom_range(0, 1)), acc);
        end
        idle(2);
        check("bp_drain", sb.size(), 0);

        // Illegal shift sets out_err and the sticky flag
        cycle(1'b1, 8'hFF, 3'd5, 3'd5, 8'h55, 8'h00, 1'b1, 1'b1, acc);
        idle(4);
        check("sticky_held", err_sticky, 1);

        // Reset with two beats in flight
        cycle(1'b1, 8'hC3, 3'd1, 3'd6, 8'h61, 8'h84, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'h3C, 3'd3, 3'd4, 8'h62, 8'h00, 1'b1, 1'b1, acc);
        do_reset();
        cycle(1'b1, 8'hB0, 3'd2, 3'd5, 8'h77, 8'hD0, 1'b0, 1'b1, acc);
        idle(3);
        check("rst_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
